memory_bus_arbiter: RTL
=======================

MEMORY_BUS_ARBITER -- requirements
Module: memory_bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4, giving the number of requesting ports (2..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 24, giving the bus data width.
REQ-003 SHALL have parameter ADDRESS_WIDTH, default 32, giving the bus address width.
REQ-004 SHALL have parameter MASTER_ID_WIDTH, default 8, giving the bus ID width (2^MASTER_ID_WIDTH >= NUM_MASTERS).
REQ-005 SHALL have parameter MAX_OUTSTANDING, default 4, giving the maximum number of unanswered reads per master.
REQ-006 SHALL have the following ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- mAddress  in  NUM_MASTERS x ADDRESS_WIDTH  per-master request address.
- mData  in  NUM_MASTERS x DATA_WIDTH  per-master write data.
- mWrite  in  NUM_MASTERS  per-master write (1) or read (0).
- mValid  in  NUM_MASTERS  per-master request valid.
- mReady  out  NUM_MASTERS  per-master request accepted.
- mRespData  out  DATA_WIDTH  read-response data, broadcast to all masters.
- mRespValid  out  NUM_MASTERS  per-master response valid.
- mRespReady  in  NUM_MASTERS  per-master response ready.
- msID, msAddress, msData, msWrite  out  MASTER_ID_WIDTH/ADDRESS_WIDTH/DATA_WIDTH/1  downstream request fields.
- msValid  out  1  downstream request valid.
- msReady  in  1  downstream request ready.
- smID, smData  in  MASTER_ID_WIDTH/DATA_WIDTH  downstream response fields.
- smValid  in  1  downstream response valid.
- smReady  out  1  downstream response ready.
- dropCount  out  8  count of responses with an unmapped ID.

Function
REQ-007 A transfer on any channel SHALL occur only in a cycle where both valid and ready are high.
REQ-008 SHALL hold one registered request slot (valid, id, address, data, write); msValid SHALL equal the slot valid bit, and ms* fields SHALL equal the slot contents.
REQ-009 The slot SHALL be loadable in a cycle when the slot is empty or msReady=1.
REQ-010 Master i SHALL be eligible when mValid[i]=1 and either mWrite[i]=1 or outstanding[i] < MAX_OUTSTANDING.
REQ-011 The winner SHALL be the first eligible master scanning upward from the round-robin pointer p, wrapping modulo NUM_MASTERS.
REQ-012 mReady[i] SHALL be 1 only when the slot is loadable and master i is the winner; at most one mReady bit SHALL be high in any cycle.
REQ-013 On a grant, the slot SHALL capture the winner's fields with id = winner index zero-extended to MASTER_ID_WIDTH, and msValid SHALL rise the next cycle (latency 1).
REQ-014 On a grant, p SHALL become (winner+1) mod NUM_MASTERS; otherwise p SHALL hold.
REQ-015 When the slot is loadable but no master is eligible, the slot valid bit SHALL clear.
REQ-016 While msValid=1 and msReady=0, the slot SHALL hold all fields stable and no grant SHALL occur.
REQ-017 Back-to-back throughput SHALL be one request per cycle while msReady=1.
REQ-018 outstanding[i] (width clog2(MAX_OUTSTANDING+1)) SHALL increment on a read grant to i and decrement on a response handshake to i; when both occur in the same cycle it SHALL be unchanged.
REQ-019 Writes SHALL produce no response and SHALL NOT change outstanding counters.
REQ-020 Response routing SHALL be combinational: when smID < NUM_MASTERS, mRespValid[smID]=smValid, smReady=mRespReady[smID], and all other mRespValid bits = 0.
REQ-021 mRespData SHALL equal smData.
REQ-022 When smID >= NUM_MASTERS, all mRespValid bits SHALL be 0, smReady SHALL be 1, and each such response handshake SHALL increment dropCount, saturating at 255.

Reset
REQ-023 With reset=1 at a rising edge, the block SHALL clear the slot (msValid=0), set p=0, clear all outstanding counters, and clear dropCount; this SHALL take precedence over any simultaneous handshake, and an in-flight slot SHALL be discarded.
REQ-024 During reset, mReady SHALL be all 0.

Verification
REQ-025 All mValid=1 (reads), msReady=1 always -> grants in order 0,1,2,3,0..., one per cycle, msID matching each grant.
REQ-026 Master 2 wins, then msReady=0 for 3 cycles -> msAddress/msData/msID=2 held stable, mReady all 0, grant resumes the cycle msReady returns.
REQ-027 Master 1 issues 4 reads with no responses -> fifth read not granted, master 3 still served; one response with smID=1 -> master 1 regranted.
REQ-028 smValid=1 with smID=7 -> smReady=1, mRespValid=0, dropCount 0->1; 300 such responses -> dropCount=255.
REQ-029 Reset asserted while msValid=1 and outstanding[0]=3 -> next cycle msValid=0, p=0, counters 0, dropCount 0.

Source files
------------

// File: rtl/memory_bus_arbiter.sv
// memory_bus_arbiter: round-robin N-master to single-slave request arbiter with read-response routing
module memory_bus_arbiter #(
   parameter int NUM_MASTERS     = 4,
   parameter int DATA_WIDTH      = 24,
   parameter int ADDRESS_WIDTH   = 32,
   parameter int MASTER_ID_WIDTH = 8,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                                   clock,
   input  logic                                   reset,
   input  logic [NUM_MASTERS*ADDRESS_WIDTH-1:0]   mAddress,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0]      mData,
   input  logic [NUM_MASTERS-1:0]                 mWrite,
   input  logic [NUM_MASTERS-1:0]                 mValid,
   output logic [NUM_MASTERS-1:0]                 mReady,
   output logic [DATA_WIDTH-1:0]                  mRespData,
   output logic [NUM_MASTERS-1:0]                 mRespValid,
   input  logic [NUM_MASTERS-1:0]                 mRespReady,
   output logic [MASTER_ID_WIDTH-1:0]             msID,
   output logic [ADDRESS_WIDTH-1:0]               msAddress,
   output logic [DATA_WIDTH-1:0]                  msData,
   output logic                                   msWrite,
   output logic                                   msValid,
   input  logic                                   msReady,
   input  logic [MASTER_ID_WIDTH-1:0]             smID,
   input  logic [DATA_WIDTH-1:0]                  smData,
   input  logic                                   smValid,
   output logic                                   smReady,
   output logic [7:0]                             dropCount
);
   localparam int PW = $clog2(NUM_MASTERS);
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);

   logic                       vld_q, vld_d;
   logic [MASTER_ID_WIDTH-1:0] id_q, id_d;
   logic [ADDRESS_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]      data_q, data_d;
   logic                       wr_q, wr_d;
   logic [PW-1:0]              ptr_q, ptr_d;
   logic [7:0]                 drop_q, drop_d;
   logic [OW-1:0]              out_q [NUM_MASTERS];
   logic [OW-1:0]              out_d [NUM_MASTERS];
   logic [NUM_MASTERS-1:0]     elig, inc, dec;
   logic                       found, load, grant, hit, resp_hs;
   logic [PW-1:0]              win, rid, idx;
   int                         t;

   assign load      = !vld_q || msReady;
   assign grant     = load && found && !reset;
   assign mReady    = NUM_MASTERS'(grant) << win;
   assign hit       = {1'b0, smID} < (MASTER_ID_WIDTH+1)'(NUM_MASTERS);
   assign rid       = smID[PW-1:0];
   assign smReady   = hit ? mRespReady[rid] : 1'b1;
   assign resp_hs   = smValid && smReady;
   assign mRespData = smData;
   assign msValid   = vld_q;
   assign msID      = id_q;
   assign msAddress = addr_q;
   assign msData    = data_q;
   assign msWrite   = wr_q;
   assign dropCount = drop_q;

   genvar i;
   generate
      for (i = 0; i < NUM_MASTERS; i++) begin : g_m
         assign elig[i]       = mValid[i] && (mWrite[i] || out_q[i] < OW'(MAX_OUTSTANDING));
         assign mRespValid[i] = smValid && hit && rid == PW'(i);
         assign inc[i]        = grant && win == PW'(i) && !mWrite[i];
         assign dec[i]        = resp_hs && hit && rid == PW'(i);
      end
   endgenerate

   // winner search from the pointer upward; the downward loop lets the nearest eligible master overwrite
   always_comb begin
      found = 1'b0;
      win   = '0;
      t     = 0;
      idx   = '0;
      for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
         t   = int'(ptr_q) + k;
         t   = t >= NUM_MASTERS ? t - NUM_MASTERS : t;
         idx = PW'(t);
         if (elig[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   // request slot, pointer and drop counter next state
   always_comb begin
      vld_d  = load ? found : vld_q;
      id_d   = grant ? MASTER_ID_WIDTH'(win) : id_q;
      addr_d = grant ? mAddress[win*ADDRESS_WIDTH +: ADDRESS_WIDTH] : addr_q;
      data_d = grant ? mData[win*DATA_WIDTH +: DATA_WIDTH] : data_q;
      wr_d   = grant ? mWrite[win] : wr_q;
      ptr_d  = grant ? (win == PW'(NUM_MASTERS - 1) ? '0 : win + 1'b1) : ptr_q;
      drop_d = (smValid && !hit && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
   end

   // unanswered-read counters; a simultaneous grant and response cancel out
   always_comb begin
      for (int m = 0; m < NUM_MASTERS; m++)
         out_d[m] = out_q[m] + OW'(inc[m]) - OW'(dec[m]);
   end

   // state registers; reset discards any in-flight slot
   always_ff @(posedge clock) begin
      vld_q  <= reset ? 1'b0 : vld_d;
      ptr_q  <= reset ? '0 : ptr_d;
      drop_q <= reset ? '0 : drop_d;
      id_q   <= id_d;
      addr_q <= addr_d;
      data_q <= data_d;
      wr_q   <= wr_d;
      for (int m = 0; m < NUM_MASTERS; m++)
         out_q[m] <= reset ? '0 : out_d[m];
   end
endmodule
